// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer between the buart receiver and the j1 IO read mux.
// Optional rts_n flow control is built when UART_RXFIFO_RTS_EN is defined.
module uart_rx_fifo #(
  parameter int ADDR = 4,
  parameter int HWM  = 12
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          uart_valid,
  input  logic [7:0]    uart_data,
  output logic          uart_rd,
  input  logic          cpu_rd,
  output logic [15:0]   rx_dout,
  output logic [ADDR:0] count,
  output logic          empty,
  output logic          full,
  output logic          rts_n
);

  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ACK    = 1'b1;
  localparam logic [ADDR:0] FULL_LVL = {1'b1, {ADDR{1'b0}}};

  logic [7:0]      mem [0:(1<<ADDR)-1];
  logic [0:0]      state_q, state_d;
  logic [ADDR-1:0] wptr_q, wptr_d;
  logic [ADDR-1:0] rptr_q, rptr_d;
  logic [ADDR:0]   count_q, count_d;
  logic            uart_rd_q, uart_rd_d;
  logic            push, pop;

  // Outputs depend only on registered state, never on cpu_rd or uart_valid.
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_LVL);
  assign count   = count_q;
  assign uart_rd = uart_rd_q;
  assign rx_dout = empty ? 16'h0000 : {8'h01, mem[rptr_q]};
  assign pop     = cpu_rd && !empty;

  always_comb begin
    // NOTE: defaults first, so no branch of this block can infer a latch.
    state_d   = state_q;
    uart_rd_d = 1'b0;
    push      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (uart_valid && !full) begin
          push      = 1'b1;
          uart_rd_d = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        // Wait for buart to drop valid so each byte is written exactly once.
        if (!uart_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetq) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      uart_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      uart_rd_q <= uart_rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/empty gate every read of stale data.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= uart_data;
  end

`ifdef UART_RXFIFO_RTS_EN
  localparam logic [ADDR:0] HWM_LVL = HWM[ADDR:0];

  logic rts_q, rts_d;

  // Follows the registered fill level, so it lags count by one cycle.
  always_comb begin
    rts_d = (count_q >= HWM_LVL);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) rts_q <= 1'b0;
    else         rts_q <= rts_d;
  end

  assign rts_n = rts_q;
`else
  assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: buart source model, queue-based reference
// model compared every cycle, plus directed literal expectations.
module tb_uart_rx_fifo;

  localparam int ADDR  = 4;
  localparam int HWM   = 12;
  localparam int DEPTH = 1 << ADDR;
`ifdef UART_RXFIFO_RTS_EN
  localparam bit RTS_ON = 1'b1;
`else
  localparam bit RTS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetq;
  logic          uart_valid;
  logic [7:0]    uart_data;
  logic          uart_rd;
  logic          cpu_rd;
  logic [15:0]   rx_dout;
  logic [ADDR:0] count;
  logic          empty;
  logic          full;
  logic          rts_n;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.ADDR(ADDR), .HWM(HWM)) dut (
    .clk        (clk),
    .resetq     (resetq),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_rd    (uart_rd),
    .cpu_rd     (cpu_rd),
    .rx_dout    (rx_dout),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .rts_n      (rts_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of stored bytes; a byte is accepted when the receiver is ready, buart
  // offers it and there is room. After an accept the receiver waits for valid low.
  logic [7:0] mq[$];
  bit         m_busy, m_rd, m_rts, m_push, m_pop;
  int         m_n;

  always @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      mq.delete();
      m_busy = 1'b0;
      m_rd   = 1'b0;
      m_rts  = 1'b0;
    end else begin
      m_n    = mq.size();
      m_pop  = cpu_rd && (m_n > 0);
      m_push = !m_busy && uart_valid && (m_n < DEPTH);
      m_rts  = RTS_ON && (m_n >= HWM);
      m_rd   = m_push;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(uart_data);
      if (m_push)                     m_busy = 1'b1;
      else if (m_busy && !uart_valid) m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cyc_count",   32'(count),   32'(mq.size()));
    check("cyc_empty",   32'(empty),   32'(mq.size() == 0));
    check("cyc_full",    32'(full),    32'(mq.size() == DEPTH));
    check("cyc_rx_dout", 32'(rx_dout), (mq.size() == 0) ? 32'h0 : {16'h0, 8'h01, mq[0]});
    check("cyc_uart_rd", 32'(uart_rd), 32'(m_rd));
    check("cyc_rts_n",   32'(rts_n),   32'(m_rts));
  end

  // ---------------- buart source model ----------------
  logic [7:0] tx_q[$];
  int         hold_cycles = 1;
  int         rd_pulses   = 0;
  bit         got_rd;

  always @(negedge clk) if (uart_rd) rd_pulses++;

  initial begin
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (tx_q.size() != 0) begin
        uart_data  = tx_q[0];
        uart_valid = 1'b1;
        got_rd     = 1'b0;
        for (int i = 0; i < 3000 && !got_rd; i++) begin
          @(negedge clk);
          if (uart_rd) got_rd = 1'b1;
        end
        if (!got_rd) check("buart_ack_timeout", 0, 1);
        repeat (hold_cycles) @(posedge clk);
        #1;
        uart_valid = 1'b0;
        void'(tx_q.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_pop(output logic [15:0] val);
    @(posedge clk); #1;
    val    = rx_dout;
    cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && !uart_valid) done = 1'b1;
    end
    if (!done) check(name, 0, 1);
  endtask

  task automatic wait_count(input int target, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (int'(count) == target) done = 1'b1;
    end
    if (!done) check(name, 32'(count), 32'(target));
  endtask

  task automatic drain(input string name);
    logic [15:0] v;
    for (int i = 0; i < 64 && mq.size() > 0; i++) do_pop(v);
    @(negedge clk);
    check(name, 32'(empty), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  logic [15:0] v;
  logic [7:0]  got[$];
  int          p0;

  initial begin
    resetq = 1'b0;
    cpu_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetq = 1'b1;

    // 1: reset state
    @(negedge clk);
    check("t1_rx_dout", 32'(rx_dout), 32'h0000);
    check("t1_empty",   32'(empty),   1);
    check("t1_full",    32'(full),    0);
    check("t1_count",   32'(count),   0);
    check("t1_uart_rd", 32'(uart_rd), 0);
    check("t1_rts_n",   32'(rts_n),   0);

    // 2: single byte, buart slow to drop valid
    hold_cycles = 2;
    p0 = rd_pulses;
    tx_q.push_back(8'h41);
    wait_idle("t2_idle_timeout");
    repeat (2) @(negedge clk);
    check("t2_rd_pulses", 32'(rd_pulses - p0), 1);
    check("t2_count",     32'(count),   1);
    check("t2_rx_dout",   32'(rx_dout), 32'h0141);
    do_pop(v);
    check("t2_pop_val",   32'(v),       32'h0141);
    check("t2_rx_after",  32'(rx_dout), 32'h0000);
    check("t2_empty",     32'(empty),   1);

    // 3: fill to full, 17th byte held until a pop frees space
    hold_cycles = 1;
    p0 = rd_pulses;
    for (int i = 0; i <= 16; i++) tx_q.push_back(8'(i));
    wait_count(16, "t3_fill_timeout");
    repeat (10) @(negedge clk);
    check("t3_full",        32'(full),       1);
    check("t3_count",       32'(count),      16);
    check("t3_held_valid",  32'(uart_valid), 1);
    check("t3_held_data",   32'(uart_data),  32'h10);
    check("t3_rd_pulses",   32'(rd_pulses - p0), 16);
    do_pop(v);
    check("t3_pop_val",     32'(v), 32'h0100);
    wait_idle("t3_idle_timeout");
    repeat (3) @(negedge clk);
    check("t3_count_refill", 32'(count),   16);
    check("t3_head",         32'(rx_dout), 32'h0101);

    // 4: drain 16 in order, then 20 pushes with interleaved pops across the wrap
    for (int i = 0; i < 16; i++) begin
      do_pop(v);
      check("t4_drain_val", 32'(v), {16'h0, 8'h01, 8'(i + 1)});
    end
    @(negedge clk);
    check("t4_empty_after_drain", 32'(empty), 1);
    got.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'h80 + 8'(i));
    for (int g = 0; g < 2000 && got.size() < 20; g++) begin
      if (mq.size() > 0) begin
        do_pop(v);
        got.push_back(v[7:0]);
        repeat (2) @(posedge clk);
      end else begin
        @(posedge clk);
      end
    end
    check("t4_got_size", 32'(got.size()), 20);
    for (int i = 0; i < got.size(); i++) check("t4_order", 32'(got[i]), 32'h80 + 32'(i));
    wait_idle("t4_idle_timeout");
    @(negedge clk);
    check("t4_empty_end", 32'(empty), 1);

    // 5a: pop while empty is ignored
    do_pop(v);
    @(negedge clk);
    check("t5_empty_pop_count", 32'(count), 0);
    check("t5_empty_pop_val",   32'(v),     32'h0000);

    // 5b: pop strobe in the same cycle as the first push
    @(posedge clk);
    tx_q.push_back(8'h5A);
    #1 cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    check("t5_sim_count", 32'(count),   1);
    check("t5_sim_head",  32'(rx_dout), 32'h015A);
    wait_idle("t5_idle_timeout");
    do_pop(v);
    check("t5_sim_pop", 32'(v), 32'h015A);

    // 5c: reset mid-burst flushes at once, held byte ingested after release
    for (int i = 0; i < 6; i++) tx_q.push_back(8'h20 + 8'(i));
    repeat (9) @(posedge clk);
    #1 resetq = 1'b0;
    #1;
    check("t5_rst_count",   32'(count),   0);
    check("t5_rst_empty",   32'(empty),   1);
    check("t5_rst_rx_dout", 32'(rx_dout), 32'h0000);
    check("t5_rst_uart_rd", 32'(uart_rd), 0);
    @(posedge clk); #1 resetq = 1'b1;
    wait_idle("t5_rst_idle_timeout");
    @(negedge clk);
    check("t5_rst_refill_nonempty", 32'(empty), 0);
    drain("t5_drained");

    // 6: rts_n threshold behaviour
    for (int i = 0; i < 12; i++) tx_q.push_back(8'h60 + 8'(i));
    wait_count(12, "t6_fill_timeout");
    check("t6_rts_at_12",    32'(rts_n), 0);
    @(negedge clk);
    check("t6_rts_after_12", 32'(rts_n), 32'(RTS_ON));
    do_pop(v);
    check("t6_pop_val", 32'(v), 32'h0160);
    @(negedge clk);
    check("t6_count_11",     32'(count), 11);
    check("t6_rts_at_11",    32'(rts_n), 32'(RTS_ON));
    @(negedge clk);
    check("t6_rts_after_11", 32'(rts_n), 0);
    wait_idle("t6_idle_timeout");
    drain("t6_drained");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
